// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage ALU.
//   WORD      default operand/result width
//   OP_WIDTH  default opcode width
//   OP_*      opcode encodings understood by alu
package alu_pkg;

  localparam int WORD     = 8;
  localparam int OP_WIDTH = 3;

  localparam int OP_SUM   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_SHL   = 5;
  localparam int OP_SHR   = 6;
  localparam int OP_PASSB = 7;

endpackage

// File: rtl/alu_flags_reg.sv
// alu_flags_reg: two-bit status register holding zero/carry for later
// conditional instructions. Synchronous active-high reset wins over write.
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, active high
//   i_we        capture i_zero/i_cf
//   i_zero      zero flag to capture
//   i_cf        carry flag to capture
//   o_zero_q    registered zero flag
//   o_cf_q      registered carry flag
module alu_flags_reg (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_we,
  input  logic i_zero,
  input  logic i_cf,
  output logic o_zero_q,
  output logic o_cf_q
);

  logic zero_q, zero_d;
  logic cf_q, cf_d;

  always_comb begin
    zero_d = zero_q;
    cf_d   = cf_q;
    if (i_we) begin
      zero_d = i_zero;
      cf_d   = i_cf;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      zero_q <= 1'b0;
      cf_q   <= 1'b0;
    end else begin
      zero_q <= zero_d;
      cf_q   <= cf_d;
    end
  end

  assign o_zero_q = zero_q;
  assign o_cf_q   = cf_q;

endmodule

// File: rtl/alu.sv
// alu: combinational WIDTH-bit integer ALU with a registered flag file.
//   i_clk       clock, used only by the flag register
//   i_rst       synchronous active-high reset of the flag register
//   i_a, i_b    unsigned operands
//   i_opcode    operation select (see alu_pkg OP_*)
//   i_flags_we  latch current o_zero/o_cf into the flag register
//   o_result    combinational result
//   o_zero      combinational, 1 iff o_result == 0
//   o_cf        combinational carry/borrow
//   o_zero_q    registered zero flag
//   o_cf_q      registered carry flag
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH    = WORD,
  parameter int OP_WIDTH = alu_pkg::OP_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  input  logic [OP_WIDTH-1:0] i_opcode,
  input  logic                i_flags_we,
  output logic [WIDTH-1:0]    o_result,
  output logic                o_zero,
  output logic                o_cf,
  output logic                o_zero_q,
  output logic                o_cf_q
);

  logic             sub;
  logic [WIDTH:0]   sum_nc;
  logic [WIDTH-1:0] arith;
  logic             arith_cf;

  assign sub = (i_opcode == OP_WIDTH'(OP_SUB));

  // One shared adder computes a + (b ^ sub) without carry-in. Its carry-out
  // gives the flag directly: for subtract, ~carry(a + ~b) is 1 iff a <= b.
  // The +1 that completes the two's complement is added to the low word only,
  // so the flag keeps that "borrow-or-equal" meaning.
  assign sum_nc   = {1'b0, i_a} + {1'b0, i_b ^ {WIDTH{sub}}};
  assign arith    = sum_nc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sub};
  assign arith_cf = sum_nc[WIDTH] ^ sub;

  always_comb begin
    o_result = '0;
    o_cf     = 1'b0;
    case (i_opcode)
      OP_WIDTH'(OP_SUM),
      OP_WIDTH'(OP_SUB): begin
        o_result = arith;
        o_cf     = arith_cf;
      end
      OP_WIDTH'(OP_AND):   o_result = i_a & i_b;
      OP_WIDTH'(OP_OR):    o_result = i_a | i_b;
      OP_WIDTH'(OP_XOR):   o_result = i_a ^ i_b;
      OP_WIDTH'(OP_SHL): begin
        o_result = {i_a[WIDTH-2:0], 1'b0};
        o_cf     = i_a[WIDTH-1];
      end
      OP_WIDTH'(OP_SHR): begin
        o_result = {1'b0, i_a[WIDTH-1:1]};
        o_cf     = i_a[0];
      end
      OP_WIDTH'(OP_PASSB): o_result = i_b;
      default: begin
        o_result = '0;
        o_cf     = 1'b0;
      end
    endcase
  end

  assign o_zero = (o_result == '0);

  alu_flags_reg u_flags (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_flags_we),
    .i_zero   (o_zero),
    .i_cf     (o_cf),
    .o_zero_q (o_zero_q),
    .o_cf_q   (o_cf_q)
  );

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_a, i_b;
  logic [2:0] i_opcode;
  logic       i_flags_we;
  logic [7:0] o_result;
  logic       o_zero, o_cf, o_zero_q, o_cf_q;

  alu dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_opcode   (i_opcode),
    .i_flags_we (i_flags_we),
    .o_result   (o_result),
    .o_zero     (o_zero),
    .o_cf       (o_cf),
    .o_zero_q   (o_zero_q),
    .o_cf_q     (o_cf_q)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       zero;
    logic       cf;
    logic       zq;
    logic       cq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // registered-flag model: value visible after the most recent edge
  logic mdl_zq, mdl_cq;

  task automatic chk(input string name, input string what,
                     input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", name, what, act, req);
    end
  endtask

  // monitor: combinational outputs settled half a cycle after drive
  initial begin
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, "result", o_result, e.res);
        chk(e.name, "zero",   {7'd0, o_zero},   {7'd0, e.zero});
        chk(e.name, "cf",     {7'd0, o_cf},     {7'd0, e.cf});
        chk(e.name, "zero_q", {7'd0, o_zero_q}, {7'd0, e.zq});
        chk(e.name, "cf_q",   {7'd0, o_cf_q},   {7'd0, e.cq});
      end
    end
  end

  // drive one vector just after a rising edge, push expectation, then let
  // the next edge update the flag model
  task automatic vec(input string name, input logic [7:0] a, input logic [7:0] b,
                     input int op, input logic we, input logic rst,
                     input logic [7:0] eres, input logic ez, input logic ecf);
    exp_t e;
    i_a = a; i_b = b; i_opcode = 3'(op); i_flags_we = we; i_rst = rst;
    e.name = name; e.res = eres; e.zero = ez; e.cf = ecf;
    e.zq = mdl_zq; e.cq = mdl_cq;
    exp_q.push_back(e);
    @(posedge i_clk);
    if (rst) begin
      mdl_zq = 1'b0; mdl_cq = 1'b0;
    end else if (we) begin
      mdl_zq = ez; mdl_cq = ecf;
    end
    #1;
  endtask

  initial begin
    i_a = '0; i_b = '0; i_opcode = '0; i_flags_we = 1'b0; i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    mdl_zq = 1'b0; mdl_cq = 1'b0;

    //   name        a      b      op        we    rst   res    z     cf
    vec("sum_3_4",   8'd3,  8'd4,  OP_SUM,   1'b0, 1'b0, 8'd7,  1'b0, 1'b0);
    vec("sum_wrap",  8'hFF, 8'd1,  OP_SUM,   1'b1, 1'b0, 8'd0,  1'b1, 1'b1);
    vec("sum_hold",  8'd3,  8'd4,  OP_SUM,   1'b0, 1'b0, 8'd7,  1'b0, 1'b0);
    vec("sub_5_3",   8'd5,  8'd3,  OP_SUB,   1'b0, 1'b0, 8'd2,  1'b0, 1'b0);
    vec("sub_3_5",   8'd3,  8'd5,  OP_SUB,   1'b0, 1'b0, 8'd254,1'b0, 1'b1);
    vec("sub_5_5",   8'd5,  8'd5,  OP_SUB,   1'b0, 1'b0, 8'd0,  1'b1, 1'b1);
    vec("and",       8'hF0, 8'hAA, OP_AND,   1'b0, 1'b0, 8'hA0, 1'b0, 1'b0);
    vec("xor",       8'hF0, 8'hAA, OP_XOR,   1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    vec("or",        8'hF0, 8'hAA, OP_OR,    1'b0, 1'b0, 8'hFA, 1'b0, 1'b0);
    vec("shl",       8'h81, 8'h00, OP_SHL,   1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
    vec("shr",       8'h01, 8'h00, OP_SHR,   1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    vec("passb_rst", 8'h5C, 8'h00, OP_PASSB, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    vec("passb",     8'h00, 8'h33, OP_PASSB, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);
    vec("shl_we",    8'h80, 8'h11, OP_SHL,   1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    vec("xor_eq",    8'h3C, 8'h3C, OP_XOR,   1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vec("sub_we",    8'h10, 8'h01, OP_SUB,   1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);
    vec("after_sub", 8'h01, 8'h01, OP_AND,   1'b0, 1'b0, 8'h01, 1'b0, 1'b0);

    i_flags_we = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge i_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Combinational WIDTH-bit integer ALU with a small registered flag file; the execute-stage arithmetic unit of the CPU core.
- Result, zero and carry are combinational from i_a, i_b and i_opcode; they are valid within the same cycle, with no clock edge needed.
- A registered copy of zero/carry (status register) is updated on a write-enable for later conditional instructions.

Parameters:
- WIDTH, `WORD (8): operand/result width in bits.
- OP_WIDTH, `OP_WIDTH (3): opcode width in bits.

Ports:
- i_clk  in  1  clock; rising edge; used only by the flag register.
- i_rst  in  1  reset; synchronous, active-high.
- i_a  in  WIDTH  operand A, unsigned.
- i_b  in  WIDTH  operand B, unsigned.
- i_opcode  in  OP_WIDTH  operation select.
- i_flags_we  in  1  latch the current o_zero/o_cf into the flag register.
- o_result  out  WIDTH  combinational result.
- o_zero  out  1  combinational; 1 iff o_result == 0.
- o_cf  out  1  combinational carry/borrow flag.
- o_zero_q  out  1  registered zero flag.
- o_cf_q  out  1  registered carry flag.

Behaviour:
- Interface: one clock i_clk; reset i_rst is synchronous and active-high.
- Opcodes from the shared header:
  - OP_SUM=0: result = (a+b) mod 2^WIDTH; cf = carry-out bit WIDTH.
  - OP_SUB=1: result = (a-b) mod 2^WIDTH; cf = 1 iff a <= b (unsigned). This equals the inverted carry-out of a + ~b. So equal operands give cf=1, and a<b also gives cf=1.
  - OP_AND=2: a & b, cf=0.
  - OP_OR=3: a | b, cf=0.
  - OP_XOR=4: a ^ b, cf=0.
  - OP_SHL=5: a << 1, LSB filled with 0; cf = a[WIDTH-1].
  - OP_SHR=6: a >> 1 logical, MSB filled with 0; cf = a[0].
  - OP_PASSB=7: result = b, cf=0.
- o_zero = (o_result == 0) for every opcode, including logical ops and shifts.
- All combinational outputs are free of X for known inputs. Unused opcode encodings (when OP_WIDTH > 3) give result=0, cf=0, zero=1.
- Combinational latency is 0 cycles. The outputs settle within one simulation delta of an input change and do not depend on i_clk or i_rst.
- Flag register, on rising i_clk:
  - i_rst=1: o_zero_q=0, o_cf_q=0. Reset has priority over i_flags_we.
  - Else if i_flags_we=1: o_zero_q<=o_zero, o_cf_q<=o_cf.
  - Else: hold.
- Reset values: o_zero_q=0 and o_cf_q=0. The combinational outputs are not affected by reset.
- Wrap-around: a SUM overflow wraps modulo 2^WIDTH with cf=1 (for example 255+1 gives 0, cf=1, zero=1).

Decomposition:
- Shared header specs.vh holds `WORD, `OP_WIDTH and `OP_SUM/`OP_SUB/`OP_AND/`OP_OR/`OP_XOR/`OP_SHL/`OP_SHR/`OP_PASSB.
- Optional sub-module alu_flags_reg for the two-bit flag register.
- Adder/subtractor shares one WIDTH+1-bit adder computing a + (b ^ {WIDTH{sub}}) + 0, with cf = carry ^ sub.

Test Plan:
- SUM: 3+4 -> result 7, cf=0, zero=0. Then 255+1 -> result 0, cf=1, zero=1.
- SUB: 5-3 -> result 2, cf=0. Then 3-5 -> result 254, cf=1. Then 5-5 -> result 0, cf=1, zero=1.
- Logic with a=11110000, b=10101010:
  - AND -> 10100000, cf=0.
  - XOR -> 01011010, cf=0.
  - OR -> 11111010, cf=0.
- Shifts/pass:
  - SHL of 10000001 -> 00000010, cf=1.
  - SHR of 00000001 -> 0, cf=1, zero=1.
  - PASSB b=0 -> zero=1.
- Flags:
  - Assert i_rst for one edge -> o_zero_q=0, o_cf_q=0.
  - Drive 255+1 with i_flags_we=1, then clock -> o_zero_q=1, o_cf_q=1.
  - Drive 3+4 with i_flags_we=0, then clock -> flags hold.
  - Set i_rst=1 and i_flags_we=1 together -> flags cleared.
